// File: rtl/color_oper_pkg.sv
// rtl/color_oper_pkg.sv - shared state type, output codes and bin threshold helper
package color_oper_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_CLASS  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_BASE = 8'h30;
  localparam logic [7:0] CODE_NONE  = 8'h00;

  function automatic int threshold(input int k, input int full_scale, input int nbins);
    return (3 * full_scale * k) / (2 * nbins);
  endfunction

endpackage

// File: rtl/color_bin_lut.sv
// rtl/color_bin_lut.sv - combinational brightness bin lookup: window average in, ASCII bin code out
module color_bin_lut
  import color_oper_pkg::*;
#(
  parameter int AW         = 10,
  parameter int NBINS      = 8,
  parameter int FULL_SCALE = 241
) (
  input  logic [AW-1:0] avg,
  output logic [7:0]    code
);

  logic [31:0] avg_ext;

  always_comb begin
    avg_ext = 32'(avg);
    code    = CODE_NONE;
    // descending scan so the smallest matching bin wins
    for (int k = NBINS; k >= 1; k--) begin
      if (avg_ext < 32'(threshold(k, FULL_SCALE, NBINS))) code = ASCII_BASE + 8'(k);
    end
  end

endmodule

// File: rtl/color_oper_classifier.sv
// rtl/color_oper_classifier.sv - windowed brightness classifier with debounced operation code output
// Optional hysteresis around the committed bin is built when COLOR_OPER_HYST_EN is defined.
module color_oper_classifier
  import color_oper_pkg::*;
#(
  parameter int CW         = 8,
  parameter int NBINS      = 8,
  parameter int FULL_SCALE = 241,
  parameter int AVG_LOG2   = 2,
  parameter int STABLE_CNT = 3,
  parameter int HYST       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] r,
  input  logic [CW-1:0] g,
  input  logic [CW-1:0] b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    oper,
  output logic          oper_valid,
  input  logic          oper_ready,
  output logic          overrun
);

  localparam int SW   = CW + 2;
  localparam int AW   = SW + AVG_LOG2;
  localparam int CNTW = AVG_LOG2 + 1;
  localparam int RW   = $clog2(STABLE_CNT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);
  localparam logic [RW-1:0]   RUN_MAX  = RW'(STABLE_CNT);

  state_t          state, state_nxt;
  logic [AW-1:0]   acc;
  logic [CNTW-1:0] cnt;
  logic [RW-1:0]   run, run_nxt;
  logic [7:0]      prev_cand, cand_q, cand, lut_code;
  logic [SW-1:0]   sum, avg;
  logic            last_smp, commit;

  assign sum      = SW'(r) + SW'(g) + SW'(b);
  assign avg      = acc[AW-1:AVG_LOG2];
  assign last_smp = (cnt == CNT_LAST);

  color_bin_lut #(
    .AW         (SW),
    .NBINS      (NBINS),
    .FULL_SCALE (FULL_SCALE)
  ) u_lut (
    .avg  (avg),
    .code (lut_code)
  );

`ifdef COLOR_OPER_HYST_EN
  logic [7:0]  cb, cn;
  logic [31:0] avg_ext, thr;

  always_comb begin
    cand    = lut_code;
    cb      = oper - ASCII_BASE;
    cn      = lut_code - ASCII_BASE;
    avg_ext = 32'(avg);
    thr     = '0;
    // T_k is the boundary shared by bins k and k+1
    for (int k = 1; k < NBINS; k++) begin
      thr = 32'(threshold(k, FULL_SCALE, NBINS));
      if (cb == 8'(k) && cn == 8'(k + 1) && (avg_ext - thr) <= 32'(HYST)) cand = oper;
      if (cb == 8'(k + 1) && cn == 8'(k) && (thr - avg_ext) <= 32'(HYST)) cand = oper;
    end
  end
`else
  assign cand = lut_code;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_smp) state_nxt = ST_CLASS;
      end
      ST_CLASS:  state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_ACCUM;
      default:   state_nxt = ST_ACCUM;
    endcase
  end

  always_comb begin
    run_nxt = RW'(1);
    if (cand_q == prev_cand) run_nxt = (run == RUN_MAX) ? run : run + RW'(1);
    commit = (state == ST_COMMIT) && (run_nxt == RUN_MAX) && (cand_q != oper);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      run        <= '0;
      prev_cand  <= CODE_NONE;
      cand_q     <= CODE_NONE;
      oper       <= CODE_NONE;
      oper_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_valid) begin
            acc <= acc + AW'(sum);
            cnt <= last_smp ? '0 : cnt + CNTW'(1);
          end
        end
        ST_CLASS: cand_q <= cand;
        ST_COMMIT: begin
          run       <= run_nxt;
          prev_cand <= cand_q;
          acc       <= '0;
        end
        default: ;
      endcase

      // a commit wins over the handshake; an unread code being replaced is an overrun
      if (commit) begin
        oper       <= cand_q;
        oper_valid <= 1'b1;
        if (oper_valid && !oper_ready) overrun <= 1'b1;
      end else if (oper_valid && oper_ready) begin
        oper_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_color_oper_classifier.sv
// tb/tb_color_oper_classifier.sv - scoreboard bench for color_oper_classifier (default build)
module tb_color_oper_classifier;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] r = '0, g = '0, b = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    oper;
  logic          oper_valid;
  logic          oper_ready = 1'b1;
  logic          overrun;

  color_oper_classifier dut (
    .clk        (clk),
    .rst        (rst),
    .r          (r),
    .g          (g),
    .b          (b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .oper       (oper),
    .oper_valid (oper_valid),
    .oper_ready (oper_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] code;
    int         due;
    bit         timed;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && oper_valid && oper_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_commit: got oper 0x%0h, expected no output", oper);
      end else begin
        e = exp_q.pop_front();
        check("commit_code", 32'(oper), 32'(e.code));
        if (e.timed) check("commit_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic send(input int s);
    int guard = 0;
    r        = CW'(s / 3);
    g        = CW'(s / 3);
    b        = CW'(s - 2 * (s / 3));
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 20 cycles");
    end
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic window(input int sa, input int sb, input bit expect_commit,
                        input logic [7:0] code, input bit timed);
    for (int i = 0; i < 3; i++) send(sa);
    send(sb);
    if (expect_commit) exp_q.push_back('{code, last_acc + 2, timed});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_oper", 32'(oper), 32'h00);
    check("rst_oper_valid", 32'(oper_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // black, then repeats that must stay silent
    for (int w = 0; w < 3; w++) window(0, 0, (w == 2), 8'h31, 1'b1);
    for (int w = 0; w < 3; w++) window(0, 0, 1'b0, 8'h00, 1'b0);
    for (int w = 0; w < 3; w++) window(300, 300, (w == 2), 8'h37, 1'b1);
    for (int w = 0; w < 3; w++) window(400, 400, (w == 2), 8'h00, 1'b1);

    // debounce: 0x32,0x32 then 0x33 x3
    window(60, 60, 1'b0, 8'h00, 1'b0);
    window(60, 60, 1'b0, 8'h00, 1'b0);
    for (int w = 0; w < 3; w++) window(120, 120, (w == 2), 8'h33, 1'b1);

    // threshold edges and truncating average (acc 179 -> avg 44)
    for (int w = 0; w < 3; w++) window(45, 45, (w == 2), 8'h32, 1'b1);
    for (int w = 0; w < 3; w++) window(44, 47, (w == 2), 8'h31, 1'b1);
    for (int w = 0; w < 3; w++) window(360, 360, (w == 2), 8'h38, 1'b1);
    for (int w = 0; w < 3; w++) window(361, 361, (w == 2), 8'h00, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained_1", 32'(exp_q.size()), 32'd0);

    // overrun: two commits with oper_ready low
    oper_ready = 1'b0;
    for (int w = 0; w < 3; w++) window(0, 0, 1'b0, 8'h00, 1'b0);
    for (int w = 0; w < 3; w++) window(195, 195, (w == 2), 8'h35, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ovr_oper", 32'(oper), 32'h35);
    check("ovr_oper_valid", 32'(oper_valid), 32'd1);
    check("ovr_overrun", 32'(overrun), 32'd1);
    oper_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_valid_cleared", 32'(oper_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("queue_drained_2", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a window
    send(400);
    send(400);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_oper", 32'(oper), 32'h00);
    check("midrst_oper_valid", 32'(oper_valid), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 3; w++) window(0, 0, (w == 2), 8'h31, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("queue_drained_3", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_oper_classifier.md
COLOR_OPER_CLASSIFIER -- requirements
Module: color_oper_classifier

Interface
REQ-001 SHALL have parameter CW, default 8: width of each colour channel.
REQ-002 SHALL have parameter NBINS, default 8, legal range 1..9: number of brightness bins.
REQ-003 SHALL have parameter FULL_SCALE, default 241: nominal per-channel full-scale value used in the threshold formula.
REQ-004 SHALL have parameter AVG_LOG2, default 2: averaging window is 2^AVG_LOG2 accepted samples.
REQ-005 SHALL have parameter STABLE_CNT, default 3, minimum 1: number of consecutive identical window results needed to commit.
REQ-006 SHALL have parameter HYST, default 4: hysteresis margin in sum units; used only under COLOR_OPER_HYST_EN.
REQ-007 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have ports r, g and b, each input, CW bits: colour sample.
REQ-010 SHALL have port in_valid, input, 1 bit: sample present. Port in_ready, output, 1 bit: sample accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port oper, output, 8 bits: committed ASCII operation code.
REQ-012 SHALL have port oper_valid, output, 1 bit, and port oper_ready, input, 1 bit: output handshake.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag for a lost output.

Function
REQ-014 SHALL sum s = r+g+b at width CW+2 and accumulate s over 2^AVG_LOG2 accepted samples; the accumulator is CW+2+AVG_LOG2 bits wide and can never overflow.
REQ-015 SHALL compute avg = acc >> AVG_LOG2, truncating.
REQ-016 SHALL use thresholds T_k = floor(3*FULL_SCALE*k / (2*NBINS)) for k=1..NBINS, computed at elaboration.
REQ-017 SHALL define the candidate bin as the smallest k with avg < T_k, giving code 0x30+k; if no k matches, the code is 0x00. Every bin, including bin NBINS, is reachable.
REQ-018 SHALL implement a state machine with three states:
- ACCUM: in_ready=1; leaves for CLASS on the cycle the final window sample is accepted.
- CLASS: in_ready=0; registers the candidate code; always goes to COMMIT.
- COMMIT: in_ready=0; runs the debounce/commit step; clears the accumulator; goes to ACCUM.
REQ-019 Debounce:
- If the candidate equals the previous candidate, the run counter increments, saturating at STABLE_CNT.
- Otherwise the run counter is set to 1.
- A commit happens when the run counter reaches STABLE_CNT and the candidate differs from oper.
REQ-020 On commit SHALL update oper and set oper_valid=1 from the next cycle, i.e. 2 cycles after the last sample is accepted. A repeated identical result SHALL produce no new commit.
REQ-021 oper_valid SHALL stay high until a cycle with oper_ready=1, and clears on the cycle after that handshake.
REQ-022 If a commit occurs while oper_valid=1 and no handshake happens that cycle, the newest code SHALL overwrite oper, oper_valid stays 1, and overrun is set.
REQ-023 If a commit and a handshake coincide, the new code SHALL be presented with oper_valid=1 and overrun is not set.
REQ-024 oper SHALL hold its value when not committing; overrun clears only on reset.

Reset
REQ-025 Asserting rst low SHALL immediately force: state ACCUM, accumulator 0, sample counter 0, run counter 0, previous candidate 0x00, oper=0x00, oper_valid=0, overrun=0.
REQ-026 in_ready SHALL be 1 while in reset and right after release.
REQ-027 Reset mid-window SHALL discard the partial window; no commit is produced from it.

Configuration
REQ-028 Macro COLOR_OPER_HYST_EN:
- Defined: in CLASS, if the candidate bin is adjacent to the committed bin and avg lies within HYST of their shared threshold, the candidate SHALL be replaced by the committed bin.
- Undefined: no hysteresis logic is built, and the HYST parameter is ignored.

Structure
REQ-029 A shared package color_oper_pkg SHALL hold the state enum typedef, the ASCII base constant 0x30, the out-of-range code 0x00 and the threshold function.
REQ-030 Bin lookup SHALL be a combinational sub-module color_bin_lut (avg in, code out); the state machine, accumulator and debounce logic stay in the top module.

Verification (defaults: thresholds 45,90,135,180,225,271,316,361; 4-sample window; STABLE_CNT=3)
REQ-031 12 samples of r=g=b=0 -> one commit, oper=0x31, oper_valid high 2 cycles after the 12th sample.
REQ-032 12 samples of r=g=b=100 (sum 300) -> oper=0x37; 12 samples with sum 400 -> oper=0x00.
REQ-033 Window results 0x32,0x32,0x33,0x33,0x33 -> exactly one commit, 0x33; no 0x32 commit.
REQ-034 oper_ready held low across two commits (0x31 then 0x35) -> oper=0x35, oper_valid=1, overrun=1.
REQ-035 rst pulsed low after 2 of 4 samples -> all outputs at reset values; the following 12 samples commit normally.
REQ-036 With COLOR_OPER_HYST_EN defined, committed 0x33 and windows with avg=136 -> no commit; avg=140 -> 0x34 commits after 3 windows.
